dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder end of the data-memory bus driven by the memory controller. Accepts one read or write request per handshake on a 64-bit row (four 16-bit lanes, one per core) and owns the storage array. Returns read data after a fixed, parameterised latency. Sits between the memory controller and the data-memory array, replacing the bare single-cycle RAM with a ready/valid responder.

## Interface
- `DEPTH`, 256: number of 64-bit rows; must be a power of two, 2..65536.
- `RD_LAT`, 2: read latency in cycles from acceptance edge to `rsp_valid`; legal range 1..4.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_read`  in  1  read request.
- `req_write`  in  1  write request.
- `req_addr`  in  16  row address.
- `req_wdata`  in  64  write data; lane k = bits [16k+15:16k].
- `req_lane_we`  in  4  per-lane write enable; bit k gates lane k.
- `req_ready`  out  1  responder can accept a request this cycle.
- `rsp_valid`  out  1  one-cycle pulse: `rsp_rdata` valid.
- `rsp_rdata`  out  64  read data.
- `rsp_wack`  out  1  one-cycle pulse acknowledging a completed write.
- `rsp_err`  out  1  address error flag, qualified by `rsp_valid` or `rsp_wack`.

## Operation
- **Acceptance:** a request is accepted at a rising edge where `req_ready`=1 and (`req_read` | `req_write`)=1. Inputs are ignored when `req_ready`=0; the controller must hold the request until accepted.
- **Write:** the array is updated at the acceptance edge, only on lanes with `req_lane_we`=1. With `req_lane_we`=0000 nothing is stored, but the write is still acknowledged.
- **Read:** the row is captured at the acceptance edge and delivered `RD_LAT` cycles later.
- **Simultaneous read and write** in the same request: the write is applied first, then the read returns the post-write row. Both `rsp_wack` and `rsp_valid` follow their own timing.
- **FSM:**
  - IDLE: `req_ready`=1. Read accept → WAIT if `RD_LAT`>1, else RESP. Write-only accept stays in IDLE.
  - WAIT: `req_ready`=0; counter runs from `RD_LAT`-2 down to 0; at 0 → RESP.
  - RESP: `rsp_valid`=1, `req_ready`=1. A new read accepted here → WAIT or RESP as from IDLE. Otherwise → IDLE.
- **Write timing:** writes are single-cycle and accepted in IDLE or RESP; they never enter WAIT.
- **Address wrap** (checker compiled out): the row index is `req_addr` mod `DEPTH`; upper bits are ignored.
- **Reset values:** state IDLE, `req_ready`=0 while `rst`=1 and 1 from the first cycle after release. `rsp_valid`=0, `rsp_wack`=0, `rsp_err`=0, `rsp_rdata`=0.
- **Array contents:** not reset.
- **`rsp_rdata` hold:** holds its last value between responses.
- **Reset during WAIT or RESP:** the pending read is dropped and no `rsp_valid` is issued after release. A write already accepted before reset remains in the array.

## Timing
- **Read latency:** accepted at edge t gives `rsp_valid` high for the cycle following edge t+`RD_LAT`-1.
- **Read throughput:** one read per `RD_LAT` cycles; full rate when `RD_LAT`=1.
- **Write acknowledge:** a write accepted at edge t gives `rsp_wack` high for the cycle following edge t.
- **Back-to-back writes:** one per cycle.
- **Write→read ordering:** a read accepted in the cycle after a write to the same row returns the new data.
- **Registered outputs:** all outputs are registered; there is no combinational path from `req_*` to any output.

## Configuration
- **Macro:** `DMEM_ADDR_CHECK_EN`.
- **Defined:** a request with `req_addr` ≥ `DEPTH` is an error.
  - An erroneous write leaves the array unchanged; `rsp_wack` still pulses, with `rsp_err`=1.
  - An erroneous read returns `rsp_rdata`=0 with `rsp_err`=1 at the normal latency.
- **Undefined:** addresses wrap modulo `DEPTH` and `rsp_err` is tied to 0.

## Structure
- **Package `dmem_pkg`:** `LANES`=4, `LANE_W`=16, `ROW_W`=64, and the `dmem_state_t` enum {IDLE, WAIT, RESP}.
- **Sub-module `dmem_array`:** a `DEPTH`×64 storage array with lane write enables and a synchronous read port.
- **`dmem_responder`:** holds the FSM, latency counter, response registers and the address checker.

## Test plan
- **Write then read:** after reset, write row 5 = 0x1111_2222_3333_4444 with we=1111, then read row 5 with `RD_LAT`=2. Expect `rsp_wack` one cycle after the write, `rsp_valid` 2 cycles after read acceptance, and data 0x1111_2222_3333_4444.
- **Lane masking:** overwrite row 5 with 0xAAAA_BBBB_CCCC_DDDD, we=0101, then read row 5. Expect 0x1111_BBBB_3333_DDDD.
- **Combined read/write:** a single request with read and write both set, row 9 = 0x0123_4567_89AB_CDEF, we=1111. Expect the read to return 0x0123_4567_89AB_CDEF.
- **Read throughput:** with `RD_LAT`=1, stream reads of rows 0..3 on consecutive cycles. Expect `req_ready` to stay 1 and `rsp_valid` high for 4 consecutive cycles with in-order data.
- **Reset mid-read:** with `RD_LAT`=4, assert `rst` during WAIT. Expect no `rsp_valid` after release, `rsp_rdata`=0, and `req_ready`=1 one cycle after release.
- **Out-of-range address:** with `DMEM_ADDR_CHECK_EN` and `DEPTH`=256, write row 0x0105, then read row 0x0105 and row 0x0005.
  - Write: `rsp_wack` with `rsp_err`=1.
  - Read of 0x0105: data 0 with `rsp_err`=1.
  - Read of 0x0005: row 5 unchanged.
  - Without the macro, the same write lands in row 5.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared row geometry, FSM state type and lane-merge helper for the data-memory responder.
package dmem_pkg;

   localparam int LANES  = 4;
   localparam int LANE_W = 16;
   localparam int ROW_W  = LANES * LANE_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   // Replace only the lanes whose write enable is set.
   function automatic logic [ROW_W-1:0] lane_merge(input logic [ROW_W-1:0] old_row,
                                                  input logic [ROW_W-1:0] wdata,
                                                  input logic [LANES-1:0] lane_we);
      logic [ROW_W-1:0] row;
      row = old_row;
      for (int k = 0; k < LANES; k++)
         if (lane_we[k]) row[k*LANE_W +: LANE_W] = wdata[k*LANE_W +: LANE_W];
      return row;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64 storage with per-lane write enables and a write-first synchronous read port.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  logic             wr_en,
   input  logic             rd_zero,
   input  logic [AW-1:0]    addr,
   input  logic [ROW_W-1:0] wdata,
   input  logic [LANES-1:0] lane_we,
   output logic [ROW_W-1:0] rd_row
);

   logic [ROW_W-1:0] mem [DEPTH];
   logic [ROW_W-1:0] row_new;

   // A combined read/write returns the row as it looks after the write.
   assign row_new = wr_en ? lane_merge(mem[addr], wdata, lane_we) : mem[addr];

   always_ff @(posedge clk) begin
      if (wr_en) mem[addr] <= row_new;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)        rd_row <= '0;
      else if (rd_en) rd_row <= rd_zero ? '0 : row_new;
   end

endmodule

// File: rtl/dmem_responder.sv
// Ready/valid responder in front of the data-memory array with RD_LAT-cycle reads.
// Optional DMEM_ADDR_CHECK_EN flags addresses >= DEPTH instead of wrapping them.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int RD_LAT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_read,
   input  logic             req_write,
   input  logic [15:0]      req_addr,
   input  logic [ROW_W-1:0] req_wdata,
   input  logic [LANES-1:0] req_lane_we,
   output logic             req_ready,
   output logic             rsp_valid,
   output logic [ROW_W-1:0] rsp_rdata,
   output logic             rsp_wack,
   output logic             rsp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0] CNT_INIT = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

   dmem_state_t      state, state_nxt;
   logic [1:0]       cnt, cnt_nxt;
   logic             acc, rd_acc, wr_acc, addr_err, rd_err_q, wait_done;
   logic [ROW_W-1:0] rd_row;

   assign acc       = req_ready & (req_read | req_write);
   assign rd_acc    = acc & req_read;
   assign wr_acc    = acc & req_write;
   assign wait_done = (state == WAIT) && (cnt == 2'd0);

`ifdef DMEM_ADDR_CHECK_EN
   assign addr_err = (req_addr >> AW) != 16'd0;
`else
   // Upper address bits are simply dropped: the row index wraps modulo DEPTH.
   logic unused_addr;
   assign unused_addr = ^req_addr;
   assign addr_err    = 1'b0;
`endif

   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_acc),
      .wr_en   (wr_acc & ~addr_err),
      .rd_zero (addr_err),
      .addr    (req_addr[AW-1:0]),
      .wdata   (req_wdata),
      .lane_we (req_lane_we),
      .rd_row  (rd_row)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         WAIT: begin
            if (cnt == 2'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 2'd1;
         end
         default: begin
            if (rd_acc) begin
               if (RD_LAT > 1) begin
                  state_nxt = WAIT;
                  cnt_nxt   = CNT_INIT;
               end else begin
                  state_nxt = RESP;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // Outputs are registered from the next-state decode so nothing is combinational from req_*.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 2'd0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_wack  <= 1'b0;
         rsp_err   <= 1'b0;
         rd_err_q  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         req_ready <= (state_nxt != WAIT);
         rsp_valid <= (state_nxt == RESP);
         rsp_wack  <= wr_acc;
         rsp_err   <= (wr_acc & addr_err) |
                      ((RD_LAT == 1) ? (rd_acc & addr_err) : (wait_done & rd_err_q));
         if (rd_acc) rd_err_q <= addr_err;
      end
   end

   generate
      if (RD_LAT == 1) begin : g_direct
         assign rsp_rdata = rd_row;
      end else begin : g_hold
         always_ff @(posedge clk or posedge rst) begin
            if (rst)            rsp_rdata <= '0;
            else if (wait_done) rsp_rdata <= rd_row;
         end
      end
   endgenerate

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: scoreboard model on an RD_LAT=2 instance,
// plus directed RD_LAT=1 streaming and RD_LAT=4 reset-during-wait checks.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int DEPTH = 256;
   localparam int LAT   = 2;
`ifdef DMEM_ADDR_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // main instance (RD_LAT=2)
   logic        rst, req_read, req_write, req_ready, rsp_valid, rsp_wack, rsp_err;
   logic [15:0] req_addr;
   logic [63:0] req_wdata, rsp_rdata;
   logic [3:0]  req_lane_we;

   dmem_responder #(.DEPTH(DEPTH), .RD_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_lane_we(req_lane_we),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_wack(rsp_wack), .rsp_err(rsp_err));

   // RD_LAT=1 instance
   logic        rst1, rd1, wr1, rdy1, v1, wk1, e1;
   logic [15:0] a1;
   logic [63:0] wd1, d1;
   logic [3:0]  we1;

   dmem_responder #(.DEPTH(DEPTH), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst1), .req_read(rd1), .req_write(wr1),
      .req_addr(a1), .req_wdata(wd1), .req_lane_we(we1),
      .req_ready(rdy1), .rsp_valid(v1), .rsp_rdata(d1),
      .rsp_wack(wk1), .rsp_err(e1));

   // RD_LAT=4 instance
   logic        rst4, rd4, wr4, rdy4, v4, wk4, e4;
   logic [15:0] a4;
   logic [63:0] wd4, d4;
   logic [3:0]  we4;

   dmem_responder #(.DEPTH(DEPTH), .RD_LAT(4)) u_dut4 (
      .clk(clk), .rst(rst4), .req_read(rd4), .req_write(wr4),
      .req_addr(a4), .req_wdata(wd4), .req_lane_we(we4),
      .req_ready(rdy4), .rsp_valid(v4), .rsp_rdata(d4),
      .rsp_wack(wk4), .rsp_err(e4));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @cyc: got %h expected %h", tag, got, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // reference model: storage image plus queues of expected responses keyed by cycle
   typedef struct {
      int          c;
      logic [63:0] d;
      logic        e;
   } exp_t;

   logic [63:0] mem_m [DEPTH];
   exp_t        qr[$];
   exp_t        qw[$];
   int          ready_at = 1 << 30;
   logic [63:0] last_d   = 64'd0;

   function automatic logic addr_err(input logic [15:0] a);
      return CHECK_EN && (a >= 16'(DEPTH));
   endfunction

   task automatic do_req(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [63:0] wd, input logic [3:0] we);
      int          to;
      int          e;
      logic [7:0]  idx;
      logic        er;
      req_read = rd; req_write = wr; req_addr = a; req_wdata = wd; req_lane_we = we;
      to = 0;
      while (!req_ready && to < 20) begin
         @(negedge clk);
         to++;
      end
      if (to >= 20) chk("accept_timeout", 64'(req_ready), 64'd1);
      e   = cyc + 1;
      idx = a[7:0];
      er  = addr_err(a);
      if (wr && !er)
         for (int k = 0; k < LANES; k++)
            if (we[k]) mem_m[idx][k*LANE_W +: LANE_W] = wd[k*LANE_W +: LANE_W];
      if (wr) qw.push_back('{e, 64'd0, er});
      if (rd) begin
         qr.push_back('{e + LAT - 1, er ? 64'd0 : mem_m[idx], er});
         ready_at = e + LAT - 1;
      end
      @(negedge clk);
      req_read = 1'b0; req_write = 1'b0;
   endtask

   // monitor for the main instance, sampled just after each rising edge
   always @(posedge clk) begin
      #1;
      begin
         bit exp_v, exp_w;
         exp_v = (qr.size() > 0) && (qr[0].c == cyc);
         exp_w = (qw.size() > 0) && (qw[0].c == cyc);
         chk("ready", 64'(req_ready), 64'(cyc >= ready_at));
         chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
         chk("rsp_wack", 64'(rsp_wack), 64'(exp_w));
         if (exp_v) begin
            chk("rd_data", rsp_rdata, qr[0].d);
            chk("rd_err", 64'(rsp_err), 64'(qr[0].e));
            last_d = qr[0].d;
            void'(qr.pop_front());
         end else begin
            chk("rdata_hold", rsp_rdata, last_d);
         end
         if (exp_w) begin
            chk("wack_err", 64'(rsp_err), 64'(qw[0].e));
            void'(qw.pop_front());
         end
         if (rst) chk("err_in_reset", 64'(rsp_err), 64'd0);
      end
   end

   logic [63:0] vals1 [4];
   logic [63:0] val4;
   int          k;
   logic [15:0] a;

   initial begin
      rst = 1'b1; rst1 = 1'b1; rst4 = 1'b1;
      req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_lane_we = 0;
      rd1 = 0; wr1 = 0; a1 = 0; wd1 = 0; we1 = 0;
      rd4 = 0; wr4 = 0; a4 = 0; wd4 = 0; we4 = 0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      ready_at = cyc + 1;
      @(negedge clk);

      // back-to-back full-row writes give every row a known value
      for (int i = 0; i < DEPTH; i++) do_req(0, 1, 16'(i), {$urandom, $urandom}, 4'hF);

      do_req(0, 1, 16'd5, 64'h1111_2222_3333_4444, 4'b1111);
      do_req(1, 0, 16'd5, 64'd0, 4'd0);
      do_req(0, 1, 16'd5, 64'hAAAA_BBBB_CCCC_DDDD, 4'b0101);
      do_req(1, 0, 16'd5, 64'd0, 4'd0);
      do_req(1, 1, 16'd9, 64'h0123_4567_89AB_CDEF, 4'b1111);
      do_req(0, 1, 16'd12, 64'hFFFF_0000_FFFF_0000, 4'b0000);
      do_req(1, 0, 16'd12, 64'd0, 4'd0);
      do_req(0, 1, 16'h0105, 64'hDEAD_BEEF_CAFE_F00D, 4'b1111);
      do_req(1, 0, 16'h0105, 64'd0, 4'd0);
      do_req(1, 0, 16'h0005, 64'd0, 4'd0);

      // reset while a read sits in WAIT: response is dropped, storage survives
      do_req(1, 0, 16'd9, 64'd0, 4'd0);
      rst = 1'b1;
      qr.delete(); qw.delete();
      last_d = 64'd0; ready_at = 1 << 30;
      @(negedge clk);
      rst = 1'b0;
      ready_at = cyc + 1;
      @(negedge clk);
      do_req(1, 0, 16'd9, 64'd0, 4'd0);

      for (int i = 0; i < 300; i++) begin
         k = $urandom_range(0, 9);
         a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
         if (k == 0) @(negedge clk);
         else do_req(k <= 5, k >= 4, a, {$urandom, $urandom}, 4'($urandom));
      end
      repeat (8) @(negedge clk);
      chk("rd_queue_drained", 64'(qr.size()), 64'd0);
      chk("wack_queue_drained", 64'(qw.size()), 64'd0);

      // RD_LAT=1: full-rate reads
      rst1 = 1'b0;
      @(negedge clk);
      chk("lat1_ready_after_reset", 64'(rdy1), 64'd1);
      for (int i = 0; i < 4; i++) begin
         vals1[i] = {$urandom, $urandom};
         wr1 = 1; a1 = 16'(i); wd1 = vals1[i]; we1 = 4'hF;
         @(negedge clk);
         chk("lat1_wack", 64'(wk1), 64'd1);
      end
      wr1 = 0;
      for (int i = 0; i < 4; i++) begin
         rd1 = 1; a1 = 16'(i);
         @(negedge clk);
         chk("lat1_ready", 64'(rdy1), 64'd1);
         chk("lat1_valid", 64'(v1), 64'd1);
         chk("lat1_data", d1, vals1[i]);
      end
      rd1 = 0;
      @(negedge clk);
      chk("lat1_valid_end", 64'(v1), 64'd0);
      chk("lat1_hold", d1, vals1[3]);

      // RD_LAT=4: reset during WAIT
      rst4 = 1'b0;
      @(negedge clk);
      val4 = {$urandom, $urandom};
      wr4 = 1; a4 = 16'd7; wd4 = val4; we4 = 4'hF;
      @(negedge clk);
      chk("lat4_wack", 64'(wk4), 64'd1);
      wr4 = 0; rd4 = 1;
      @(negedge clk);
      rd4 = 0;
      chk("lat4_wait_ready", 64'(rdy4), 64'd0);
      @(negedge clk);
      rst4 = 1'b1;
      @(negedge clk);
      chk("lat4_ready_in_reset", 64'(rdy4), 64'd0);
      rst4 = 1'b0;
      @(negedge clk);
      chk("lat4_ready_after_reset", 64'(rdy4), 64'd1);
      for (int j = 0; j < 6; j++) begin
         chk("lat4_no_valid", 64'(v4), 64'd0);
         chk("lat4_rdata_zero", d4, 64'd0);
         @(negedge clk);
      end
      rd4 = 1; a4 = 16'd7;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         rd4 = 0;
         chk("lat4_valid", 64'(v4), 64'(j == 3));
         if (j == 3) chk("lat4_data", d4, val4);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
